// File: rtl/bp_me_mem_cmd_responder.sv
// bp_me_mem_cmd_responder
//   Single-outstanding memory command responder backed by a block array.
//   A command is accepted in e_ready. A write updates the backing store on the
//   transfer cycle. A read samples its data when the FSM enters e_resp. The
//   response is held until it is consumed with yumi.
//
// Optional feature macro: BP_ME_MEM_RESPONDER_CHECK_EN
//   When defined, error_o is a sticky flag. It sets on an unsupported message
//   type, on a misaligned or oversized command, and on yumi asserted without a
//   valid response. When undefined, error_o is tied to 0.
//
// Ports
//   clk_i, reset_i              clock, asynchronous active-high reset
//   mem_cmd_*                   command channel (valid / ready_and handshake)
//   mem_resp_*                  response channel (valid / yumi handshake),
//                               echoes the command fields and carries read data
//   error_o                     sticky protocol/command error flag
module bp_me_mem_cmd_responder #(
  parameter int paddr_width_p   = 40,
  parameter int data_width_p    = 512,
  parameter int mem_els_p       = 1024,
  parameter int latency_p       = 4,
  parameter int payload_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       mem_cmd_v_i,
  output logic                       mem_cmd_ready_and_o,
  input  logic [3:0]                 mem_cmd_msg_type_i,
  input  logic [2:0]                 mem_cmd_size_i,
  input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
  input  logic [payload_width_p-1:0] mem_cmd_payload_i,
  input  logic [data_width_p-1:0]    mem_cmd_data_i,

  output logic                       mem_resp_v_o,
  input  logic                       mem_resp_yumi_i,
  output logic [3:0]                 mem_resp_msg_type_o,
  output logic [2:0]                 mem_resp_size_o,
  output logic [paddr_width_p-1:0]   mem_resp_addr_o,
  output logic [payload_width_p-1:0] mem_resp_payload_o,
  output logic [data_width_p-1:0]    mem_resp_data_o,

  output logic                       error_o
);

  // state   | meaning
  // e_ready | idle, accepting a command
  // e_wait  | command captured, latency counter running down
  // e_resp  | response valid, waiting for yumi
  localparam logic [1:0] e_ready = 2'd0;
  localparam logic [1:0] e_wait  = 2'd1;
  localparam logic [1:0] e_resp  = 2'd2;

  localparam logic [3:0] msg_rd    = 4'd0;
  localparam logic [3:0] msg_wr    = 4'd1;
  localparam logic [3:0] msg_uc_rd = 4'd2;
  localparam logic [3:0] msg_uc_wr = 4'd3;

  localparam int block_bytes_lp    = data_width_p / 8;
  localparam int lg_block_bytes_lp = $clog2(block_bytes_lp);
  localparam int lg_mem_els_lp     = $clog2(mem_els_p);
  localparam logic [7:0] cnt_init_lp = (latency_p == 0) ? 8'd0 : 8'(latency_p - 1);

  typedef logic [lg_block_bytes_lp-1:0] off_t;

  function automatic off_t size_mask(input logic [2:0] size);
    logic [15:0] m;
    m = (16'd1 << size) - 16'd1;
    return m[lg_block_bytes_lp-1:0];
  endfunction

  // Legal when the size fits in a block and the address is size-aligned.
  function automatic logic size_ok(input logic [2:0] size, input off_t off);
    return ({5'd0, size} <= 8'(lg_block_bytes_lp)) && ((off & size_mask(size)) == '0);
  endfunction

  function automatic logic is_read(input logic [3:0] t);
    return (t == msg_rd) || (t == msg_uc_rd);
  endfunction

  function automatic logic is_write(input logic [3:0] t);
    return (t == msg_wr) || (t == msg_uc_wr);
  endfunction

  // Byte position relative to the offset; wraps modulo the block size.
  function automatic off_t rel_idx(input int i, input off_t off);
    return off_t'(i) - off;
  endfunction

  // Replicates the 2^size bytes at off across the whole bus.
  function automatic logic [data_width_p-1:0] rd_rep(input logic [data_width_p-1:0] blk,
                                                     input logic [2:0] size, input off_t off);
    logic [data_width_p-1:0] res;
    off_t j;
    res = '0;
    for (int i = 0; i < block_bytes_lp; i++) begin
      j = off + (off_t'(i) & size_mask(size));
      res[8*i +: 8] = blk[8*j +: 8];
    end
    return res;
  endfunction

  logic [1:0]                 state_r;
  logic [7:0]                 cnt_r;
  logic [3:0]                 msg_type_r;
  logic [2:0]                 size_r;
  logic [paddr_width_p-1:0]   addr_r;
  logic [payload_width_p-1:0] payload_r;
  logic [data_width_p-1:0]    resp_data_r;
  logic [data_width_p-1:0]    mem_r [mem_els_p];

  logic                       cmd_xfer, cmd_wr_en, resp_enter;
  logic [lg_mem_els_lp-1:0]   cmd_idx, sel_idx;
  off_t                       cmd_off, sel_off;
  logic [3:0]                 sel_type;
  logic [2:0]                 sel_size;
  logic [block_bytes_lp-1:0]  wr_be;
  logic [data_width_p-1:0]    wr_data, rd_sample;

  assign mem_cmd_ready_and_o = (state_r == e_ready) && !reset_i;
  assign mem_resp_v_o        = (state_r == e_resp);
  assign cmd_xfer            = mem_cmd_v_i && mem_cmd_ready_and_o;

  assign cmd_idx = mem_cmd_addr_i[lg_block_bytes_lp +: lg_mem_els_lp];
  assign cmd_off = mem_cmd_addr_i[lg_block_bytes_lp-1:0];

  assign cmd_wr_en = cmd_xfer && is_write(mem_cmd_msg_type_i) && size_ok(mem_cmd_size_i, cmd_off);

  // Shift write data up to the offset and enable only [off, off+2^size).
  always_comb begin
    wr_be   = '0;
    wr_data = '0;
    for (int i = 0; i < block_bytes_lp; i++) begin
      wr_be[i]          = (rel_idx(i, cmd_off) <= size_mask(mem_cmd_size_i));
      wr_data[8*i +: 8] = mem_cmd_data_i[8*rel_idx(i, cmd_off) +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_wr_en) begin
      for (int i = 0; i < block_bytes_lp; i++) begin
        if (wr_be[i]) mem_r[cmd_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // With zero latency e_resp is entered straight from e_ready, so the read is
  // taken from the live command fields instead of the captured ones.
  always_comb begin
    if (state_r == e_ready) begin
      sel_type = mem_cmd_msg_type_i;
      sel_size = mem_cmd_size_i;
      sel_idx  = cmd_idx;
      sel_off  = cmd_off;
    end else begin
      sel_type = msg_type_r;
      sel_size = size_r;
      sel_idx  = addr_r[lg_block_bytes_lp +: lg_mem_els_lp];
      sel_off  = addr_r[lg_block_bytes_lp-1:0];
    end
  end

  assign rd_sample = (is_read(sel_type) && size_ok(sel_size, sel_off))
                   ? rd_rep(mem_r[sel_idx], sel_size, sel_off) : '0;

  assign resp_enter = (cmd_xfer && (latency_p == 0)) || ((state_r == e_wait) && (cnt_r == 8'd0));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        e_ready: if (cmd_xfer) begin
          if (latency_p == 0) begin
            state_r <= e_resp;
          end else begin
            state_r <= e_wait;
            cnt_r   <= cnt_init_lp;
          end
        end
        e_wait: if (cnt_r == 8'd0) state_r <= e_resp;
                else cnt_r <= cnt_r - 8'd1;
        e_resp: if (mem_resp_yumi_i) state_r <= e_ready;
        default: state_r <= e_ready;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_xfer) begin
      msg_type_r <= mem_cmd_msg_type_i;
      size_r     <= mem_cmd_size_i;
      addr_r     <= mem_cmd_addr_i;
      payload_r  <= mem_cmd_payload_i;
    end
    if (resp_enter) resp_data_r <= rd_sample;
  end

  assign mem_resp_msg_type_o = msg_type_r;
  assign mem_resp_size_o     = size_r;
  assign mem_resp_addr_o     = addr_r;
  assign mem_resp_payload_o  = payload_r;
  assign mem_resp_data_o     = resp_data_r;

`ifdef BP_ME_MEM_RESPONDER_CHECK_EN
  logic error_r;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if ((cmd_xfer && ((mem_cmd_msg_type_i > msg_uc_wr) || !size_ok(mem_cmd_size_i, cmd_off)))
              || (mem_resp_yumi_i && !mem_resp_v_o)) begin
      error_r <= 1'b1;
    end
  end
  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule
